// File: rtl/usb_bus_pkg.sv
// usb_bus_pkg: shared widths, address-space bit, command layout and FSM
// encoding for the USB register bus master.
package usb_bus_pkg;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 16;
    // Address bit that selects endpoint-status space (1) versus CSR space (0).
    localparam int EP_SPACE_BIT = 11;
    // One queued command: write flag, address, write data.
    localparam int CMD_W        = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CYC  = 2'd1,
        ST_RSP  = 2'd2,
        ST_GAP  = 2'd3
    } bus_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // True when an address targets endpoint-status space rather than CSRs.
    function automatic logic is_ep_space(input logic [ADDR_W-1:0] addr);
        return addr[EP_SPACE_BIT];
    endfunction

endpackage

// File: rtl/usb_bus_fifo.sv
// usb_bus_fifo: command queue for usb_bus_master. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
// The head entry is read combinationally so the master can register it onto
// the bus at the same edge it pops.
module usb_bus_fifo
    import usb_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer update; wrap is implicit since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_bus_master.sv
// usb_bus_master: accepts read/write commands into a small queue and runs
// them strictly in order as single bus cycles, returning one response each.
// Cycle sequence is IDLE -> CYC -> RSP -> GAP -> IDLE, so at least one idle
// bus cycle separates consecutive transfers.
// Build option: define USB_BUS_MASTER_TIMEOUT_EN to abort a cycle that sees no
// bus_ack within TIMEOUT cycles (response then carries rsp_err = 1).
module usb_bus_master
    import usb_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_din,
    input  logic [DATA_W-1:0] bus_dout,
    output logic              bus_cyc,
    output logic              bus_we,
    input  logic              bus_ack,
    output logic              busy
);

    // Elaboration-time parameter sanity.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("usb_bus_master: FIFO_DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("usb_bus_master: TIMEOUT must be in 1..65535");
    end

    bus_state_t        state_q, state_d;
    logic              bus_cyc_q, bus_cyc_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_din_q, bus_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_wdata;
    logic [CMD_W-1:0]  fifo_rdata;
    bus_cmd_t          head;

`ifdef USB_BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic              rsp_err_q, rsp_err_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
`endif

    assign fifo_wdata = {cmd_we, cmd_addr, cmd_wdata};
    assign fifo_push  = cmd_valid && !fifo_full;
    assign head       = fifo_rdata;

    usb_bus_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state and output-register logic for the bus cycle sequencer.
    always_comb begin
        state_d     = state_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_din_d   = bus_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;
`ifdef USB_BUS_MASTER_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Launch the oldest command; bus fields then stay frozen for the whole cycle.
                if (!fifo_empty && !rsp_valid_q) begin
                    fifo_pop   = 1'b1;
                    state_d    = ST_CYC;
                    bus_cyc_d  = 1'b1;
                    bus_we_d   = head.we;
                    bus_addr_d = head.addr;
                    bus_din_d  = head.we ? head.wdata : '0;
`ifdef USB_BUS_MASTER_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end
            ST_CYC: begin
                if (bus_ack) begin
                    state_d     = ST_RSP;
                    bus_cyc_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_we_q ? '0 : bus_dout;
`ifdef USB_BUS_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Slave never answered: abandon the cycle and report an error.
                    state_d     = ST_RSP;
                    bus_cyc_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 16'd1;
`endif
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_GAP;
                    rsp_valid_d = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any cycle in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_din_q   <= bus_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef USB_BUS_MASTER_TIMEOUT_EN
    // Wait counter and error flag exist only when the timeout is built in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            rsp_err_q <= rsp_err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = !fifo_full;
    assign bus_cyc   = bus_cyc_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_din   = bus_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = !fifo_empty || bus_cyc_q || rsp_valid_q;

endmodule

// File: tb/tb_usb_bus_master.sv
// tb_usb_bus_master: directed stimulus against usb_bus_master with a
// transaction-level reference model checked every cycle, plus hand-computed
// expectations for each scenario.
`timescale 1ns/1ps
module tb_usb_bus_master;

    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_we    = 1'b0;
    logic [11:0] cmd_addr  = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] bus_addr;
    logic [15:0] bus_din;
    logic [15:0] bus_dout  = '0;
    logic        bus_cyc;
    logic        bus_we;
    logic        bus_ack   = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_bus_master #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_addr  (bus_addr),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_ack   (bus_ack),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave responder ----------------
    int          ack_delay = 0;   // ack in the Nth cycle of bus_cyc; 0 = never
    bit          use_fixed = 0;
    logic [15:0] fixed_data = '0;
    bit          stray = 0;       // forces an ack pulse regardless of bus_cyc
    int          sl_cnt = 0;

    always @(negedge clk) begin
        if (bus_cyc) sl_cnt++;
        else         sl_cnt = 0;
        bus_ack  = (bus_cyc && ack_delay != 0 && sl_cnt == ack_delay) || stray;
        bus_dout = use_fixed ? fixed_data : (16'h5000 ^ {4'h0, bus_addr});
    end

    // ---------------- reference model ----------------
    // Queue of accepted commands; a command may start once it is queued,
    // no response is outstanding and two edges have passed since the last
    // response was taken.
    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
    } cmd_s;

    cmd_s        m_q[$];
    cmd_s        m_act;
    bit          m_active = 0;
    bit          m_pend   = 0;
    bit          m_err    = 0;
    logic [15:0] m_rdata  = '0;
    int          n_edge    = 0;
    int          m_free_at = 0;
    int          m_start_n = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_active  = 0;
            m_pend    = 0;
            m_err     = 0;
            m_rdata   = '0;
            m_free_at = 0;
        end else begin : model_edge
            int pre_size;
            bit pre_active;
            bit pre_pend;
            n_edge++;
            pre_size   = m_q.size();
            pre_active = m_active;
            pre_pend   = m_pend;
            if (pre_active) begin
                if (bus_ack) begin
                    m_active = 0;
                    m_pend   = 1;
                    m_err    = 0;
                    m_rdata  = m_act.we ? 16'h0000 : bus_dout;
                end
`ifdef USB_BUS_MASTER_TIMEOUT_EN
                else if (n_edge - m_start_n == TO) begin
                    m_active = 0;
                    m_pend   = 1;
                    m_err    = 1;
                    m_rdata  = 16'h0000;
                end
`endif
            end
            if (pre_pend && rsp_ready) begin
                m_pend    = 0;
                m_free_at = n_edge + 2;
            end
            if (!pre_active && !pre_pend && n_edge >= m_free_at && pre_size > 0) begin
                m_act     = m_q.pop_front();
                m_active  = 1;
                m_start_n = n_edge;
            end
            if (cmd_valid && pre_size < DEPTH) begin
                m_q.push_back('{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
            chk("bus_cyc",   32'(bus_cyc),   32'(m_active));
            chk("busy",      32'(busy),      32'(m_q.size() > 0 || m_active || m_pend));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
            if (m_active) begin
                chk("bus_addr", 32'(bus_addr), 32'(m_act.addr));
                chk("bus_we",   32'(bus_we),   32'(m_act.we));
                chk("bus_din",  32'(bus_din),  32'(m_act.we ? m_act.wdata : 16'h0000));
            end
            if (m_pend) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
                chk("rsp_err",   32'(rsp_err),   32'(m_err));
            end
        end
    end

    // ---------------- observation monitors ----------------
    logic [15:0] obs_q[$];
    int          obs_rsp = 0;
    int          rise_cnt = 0;
    int          low_run = 0;
    int          min_gap = 1000;
    bit          had_fall = 0;
    bit          prev_cyc = 0;

    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            obs_rsp++;
            obs_q.push_back(rsp_rdata);
            $display("RSP #%0d rdata=0x%04h err=%0d", obs_rsp, rsp_rdata, rsp_err);
        end
    end

    always @(negedge clk) begin
        if (bus_cyc && !prev_cyc) begin
            rise_cnt++;
            if (had_fall && low_run < min_gap) min_gap = low_run;
            low_run = 0;
        end else if (!bus_cyc) begin
            if (prev_cyc) had_fall = 1;
            low_run++;
        end
        prev_cyc = bus_cyc;
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic we, input logic [11:0] a, input logic [15:0] d);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("push_accepted", 32'(guard < 200), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("CMD we=%0d addr=0x%03h wdata=0x%04h", we, a, d);
    endtask

    task automatic wait_rsp(input int bound, output int hi, output bit seen, output logic [28:0] first);
        hi    = 0;
        seen  = 0;
        first = '0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
            end else if (bus_cyc) begin
                if (hi == 0) first = {bus_we, bus_addr, bus_din};
                hi++;
            end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          hi;
        bit          seen;
        logic [28:0] fb;
        int          base;
        int          guard;
        int          r0;
        bit          any_act;

        repeat (3) @(negedge clk);
        chk("rst_bus_cyc",   32'(bus_cyc),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_bus_addr",  32'(bus_addr),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // stray ack with the bus idle must be ignored
        stray = 1;
        @(negedge clk);
        stray = 0;
        @(negedge clk);
        chk("stray_idle_cyc", 32'(bus_cyc),   32'd0);
        chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);

        // write 0x000 / 0xC0DE, ack in 2nd cycle
        ack_delay = 2;
        push(1'b1, 12'h000, 16'hC0DE);
        chk("wr_no_fallthrough", 32'(bus_cyc), 32'd0);
        wait_rsp(50, hi, seen, fb);
        chk("wr_rsp_seen",   32'(seen), 32'd1);
        chk("wr_cyc_len",    32'(hi),   32'd2);
        chk("wr_bus_fields", 32'(fb),   32'({1'b1, 12'h000, 16'hC0DE}));
        chk("wr_rdata",      32'(rsp_rdata), 32'h0000);
        chk("wr_err",        32'(rsp_err),   32'd0);
        consume();
        chk("wr_rsp_cleared", 32'(rsp_valid), 32'd0);

        // read 0x805, slave returns 0x1234 in 4th cycle
        ack_delay  = 4;
        use_fixed  = 1;
        fixed_data = 16'h1234;
        push(1'b0, 12'h805, 16'hFFFF);
        wait_rsp(50, hi, seen, fb);
        chk("rd_rsp_seen",   32'(seen), 32'd1);
        chk("rd_cyc_len",    32'(hi),   32'd4);
        chk("rd_bus_fields", 32'(fb),   32'({1'b0, 12'h805, 16'h0000}));
        chk("rd_rdata",      32'(rsp_rdata), 32'h1234);
        chk("rd_cyc_dropped", 32'(bus_cyc),  32'd0);
        consume();
        use_fixed = 0;

        // five back-to-back reads with rsp_ready held high
        ack_delay = 2;
        rsp_ready = 1'b1;
        obs_q.delete();
        base     = obs_rsp;
        r0       = rise_cnt;
        had_fall = 0;
        min_gap  = 1000;
        for (int i = 0; i < 5; i++) push(1'b0, 12'(12'h010 + i), 16'h0000);
        chk("burst_full_ready_low", 32'(cmd_ready), 32'd0);
        guard = 0;
        while (obs_rsp < base + 5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("burst_rsp_count", 32'(obs_rsp - base),  32'd5);
        chk("burst_cyc_count", 32'(rise_cnt - r0),   32'd5);
        chk("burst_idle_gap",  32'(min_gap >= 1),    32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("burst_order", (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF, 32'(16'h5010 + i));
        end
        rsp_ready = 1'b0;
        @(negedge clk);

        // backpressure: second cycle must wait for rsp_ready
        ack_delay = 1;
        push(1'b0, 12'h020, 16'h0000);
        push(1'b0, 12'h021, 16'h0000);
        wait_rsp(50, hi, seen, fb);
        chk("bp_first_seen", 32'(seen),      32'd1);
        chk("bp_first_data", 32'(rsp_rdata), 32'h5020);
        r0    = rise_cnt;
        stray = 1;
        @(negedge clk);
        stray = 0;
        repeat (10) @(negedge clk);
        chk("bp_no_second_cyc", 32'(rise_cnt - r0), 32'd0);
        chk("bp_rsp_held",      32'(rsp_valid),     32'd1);
        chk("bp_rdata_held",    32'(rsp_rdata),     32'h5020);
        base      = obs_rsp;
        rsp_ready = 1'b1;
        guard     = 0;
        while (obs_rsp < base + 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_both_taken", 32'(obs_rsp - base), 32'd2);
        chk("bp_second_data", (obs_q.size() > 0) ? 32'(obs_q[obs_q.size()-1]) : 32'hFFFF_FFFF, 32'h5021);
        rsp_ready = 1'b0;
        @(negedge clk);

        // slave never acks
        ack_delay = 0;
        push(1'b0, 12'h030, 16'h0000);
`ifdef USB_BUS_MASTER_TIMEOUT_EN
        wait_rsp(60, hi, seen, fb);
        chk("tmo_rsp_seen", 32'(seen),      32'd1);
        chk("tmo_cyc_len",  32'(hi),        32'(TO));
        chk("tmo_err",      32'(rsp_err),   32'd1);
        chk("tmo_rdata",    32'(rsp_rdata), 32'h0000);
        consume();
`else
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_cyc) hi++;
        end
        chk("notmo_cyc_held", 32'(hi),        32'd20);
        chk("notmo_no_rsp",   32'(rsp_valid), 32'd0);
`endif
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("recover_idle", 32'(busy), 32'd0);

        // reset during an active cycle with three commands queued
        ack_delay = 0;
        for (int i = 0; i < 4; i++) push(1'b0, 12'(12'h040 + i), 16'h0000);
        chk("mid_rst_pre_cyc",  32'(bus_cyc), 32'd1);
        chk("mid_rst_pre_busy", 32'(busy),    32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc",       32'(bus_cyc),   32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_bus_addr",  32'(bus_addr),  32'd0);
        chk("mid_rst_bus_we",    32'(bus_we),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        any_act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_cyc || rsp_valid || busy) any_act = 1;
        end
        chk("post_rst_quiet", 32'(any_act), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_bus_master.md
USB_BUS_MASTER -- requirements
Module: usb_bus_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, max wait cycles per bus cycle (1..65535).
REQ-003 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command FIFO not full.
REQ-007 SHALL have port cmd_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  in  12  target address (bit 11 = EP status space, else CSR).
REQ-009 SHALL have port cmd_wdata  in  16  write data.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed.
REQ-012 SHALL have port rsp_rdata  out  16  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  out  1  cycle timed out.
REQ-014 SHALL have port bus_addr  out  12  slave address.
REQ-015 SHALL have port bus_din  out  16  data to slave.
REQ-016 SHALL have port bus_dout  in  16  data from slave.
REQ-017 SHALL have port bus_cyc  out  1  cycle active.
REQ-018 SHALL have port bus_we  out  1  write cycle.
REQ-019 SHALL have port bus_ack  in  1  slave completion.
REQ-020 SHALL have port busy  out  1  FIFO non-empty, cycle active or response pending.

Function
REQ-021 SHALL push a command on any edge with cmd_valid & cmd_ready; cmd_ready = FIFO not full, from registered state only.
REQ-022 SHALL run FSM IDLE -> CYC -> RSP -> GAP -> IDLE.
REQ-023 IDLE: with FIFO non-empty and no response pending, SHALL pop one entry and enter CYC at the same edge; bus_cyc high one cycle after acceptance into an empty FIFO (no fall-through).
REQ-024 CYC: bus_addr, bus_we, bus_din SHALL hold stable while bus_cyc high; bus_din = 0 for reads.
REQ-025 CYC with bus_ack high SHALL, at that edge: drop bus_cyc, capture bus_dout into rsp_rdata for reads (0 for writes), clear rsp_err, set rsp_valid, enter RSP.
REQ-026 rsp_valid SHALL hold with stable rsp_* until an edge with rsp_ready high, then clear and enter GAP.
REQ-027 GAP SHALL last exactly one cycle with bus_cyc low, guaranteeing >=1 idle cycle between bus cycles.
REQ-028 bus_ack outside CYC SHALL be ignored.
REQ-029 Simultaneous push and pop SHALL be allowed when FIFO neither full nor empty; push to full FIFO SHALL be impossible (cmd_ready low); pointers wrap modulo FIFO_DEPTH.
REQ-030 Commands SHALL complete strictly in order, one response per command.

Reset
REQ-031 rst SHALL asynchronously force: FSM IDLE, FIFO empty, bus_cyc 0, bus_we 0, bus_addr 0, bus_din 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, busy 0, cmd_ready 1 (after release).
REQ-032 rst mid-cycle SHALL abandon the cycle and discard queued commands; no response produced.

Configuration
REQ-033 Macro USB_BUS_MASTER_TIMEOUT_EN defined: 16-bit counter cleared on CYC entry; if TIMEOUT cycles elapse in CYC without bus_ack, SHALL drop bus_cyc, return rsp_err 1, rsp_rdata 0, enter RSP.
REQ-034 Macro undefined: no counter, rsp_err tied 0, CYC waits indefinitely for bus_ack.

Structure
REQ-035 FSM state encodings, address-space bit index (11) and data/address widths SHALL live in shared package usb_bus_pkg.
REQ-036 Command FIFO SHALL be sub-module usb_bus_fifo (29-bit entries: we, addr, wdata; full/empty flags).

Verification
REQ-037 Write 0x000/0xC0DE, slave acks 2 cycles after cyc -> bus_we 1, bus_din 0xC0DE stable, rsp_valid with rdata 0, err 0.
REQ-038 Read 0x805, slave acks with bus_dout 0x1234 after 4 cycles -> rsp_rdata 0x1234, bus_cyc low following edge.
REQ-039 Push 5 commands back-to-back with FIFO_DEPTH 4, rsp_ready held 1 -> cmd_ready low when full, 5 in-order responses, >=1 idle cycle between cycles.
REQ-040 rsp_ready held 0 after first response -> no second bus_cyc until rsp_ready high.
REQ-041 TIMEOUT_EN, TIMEOUT 8, no ack -> bus_cyc high exactly 8 cycles, rsp_err 1, rdata 0; without macro cyc stays high.
REQ-042 Assert rst while bus_cyc high with 3 queued -> bus_cyc 0 immediately, FIFO empty, no rsp_valid after release.
